// File: rtl/adc_entropy_capture.sv
// Packs P_LSB_BITS low bits of each in-range registered ADC sample into 32-bit entropy words; word valid on the edge that captures its last sample.
// A completed word is dropped (sticky overflow) when the output still holds an unaccepted word and m_ready is low.
module adc_entropy_capture #(
    parameter int P_LSB_BITS      = 1,
    parameter bit P_CHECK_COUNTER = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [13:0] adc_data,
    input  logic        adc_or,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        overflow,
    output logic [15:0] or_cnt,
    output logic [15:0] pattern_err_cnt,
    input  logic        clear_status
);

    localparam int SW = 32 - P_LSB_BITS;

    typedef enum logic {SYNC, RUN} chk_state_t;

    logic [13:0]           s_data_q;
    logic                  s_or_q, s_en_q;
    logic [SW-1:0]         shreg_q, shreg_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [31:0]           m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           or_cnt_q, or_cnt_d;
    logic [15:0]           err_cnt_q, err_cnt_d;
    chk_state_t            chk_q, chk_d;
    logic [13:0]           exp_q, exp_d;

    logic                  sample_vld;
    logic [P_LSB_BITS-1:0] new_bits;
    logic [31:0]           word;
    logic [5:0]            cnt_sum;
    logic                  err_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_data_q   <= '0;
            s_or_q     <= 1'b0;
            s_en_q     <= 1'b0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            overflow_q <= 1'b0;
            or_cnt_q   <= '0;
            err_cnt_q  <= '0;
            chk_q      <= SYNC;
            exp_q      <= '0;
        end else begin
            s_data_q   <= adc_data;
            s_or_q     <= adc_or;
            s_en_q     <= enable;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            overflow_q <= overflow_d;
            or_cnt_q   <= or_cnt_d;
            err_cnt_q  <= err_cnt_d;
            chk_q      <= chk_d;
            exp_q      <= exp_d;
        end
    end

    always_comb begin
        sample_vld = s_en_q & ~s_or_q;
        new_bits   = s_data_q[P_LSB_BITS-1:0];
        word       = {shreg_q, new_bits};
        cnt_sum    = {1'b0, cnt_q} + 6'(P_LSB_BITS);

        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q & ~m_ready;
        overflow_d = overflow_q;

        // Disabled capture keeps the packer empty, so a re-enable starts a fresh word.
        if (!s_en_q) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (sample_vld) begin
            shreg_d = word[SW-1:0];
            cnt_d   = cnt_sum[4:0];
            if (cnt_sum == 6'd32) begin
                if (!m_valid_q || m_ready) begin
                    m_data_d  = word;
                    m_valid_d = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
        if (clear_status) begin
            overflow_d = 1'b0;
        end

        chk_d   = chk_q;
        exp_d   = exp_q;
        err_inc = 1'b0;
        if (P_CHECK_COUNTER) begin
            if (!s_en_q) begin
                chk_d = SYNC;
            end else begin
                // Both a match and a mismatch leave expected = sample + 1 (resync on error).
                exp_d = s_data_q + 14'd1;
                case (chk_q)
                    SYNC:    chk_d = RUN;
                    RUN:     err_inc = (s_data_q != exp_q);
                    default: chk_d = SYNC;
                endcase
            end
        end

        or_cnt_d = or_cnt_q;
        if (clear_status) begin
            or_cnt_d = '0;
        end else if (s_en_q && s_or_q && or_cnt_q != 16'hFFFF) begin
            or_cnt_d = or_cnt_q + 16'd1;
        end

        err_cnt_d = err_cnt_q;
        if (clear_status) begin
            err_cnt_d = '0;
        end else if (err_inc && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    assign m_data          = m_data_q;
    assign m_valid         = m_valid_q;
    assign overflow        = overflow_q;
    assign or_cnt          = or_cnt_q;
    assign pattern_err_cnt = err_cnt_q;

endmodule

// File: doc/adc_entropy_capture.md
Name: adc_entropy_capture

Overview:
- Consumer end of the ADC path. Takes the 14-bit system-side sample stream (live ADC data or the 14-bit counter test pattern) plus the over-range flag.
- Extracts P_LSB_BITS low bits per valid sample and packs them into 32-bit entropy words. Words leave on a valid/ready stream towards the RNG post-processing.
- Optional checker verifies the counter test pattern. Status counters go to the register bank.

Parameters:
- P_LSB_BITS, 1, LSBs taken per sample; legal values 1, 2, 4, 8 (must divide 32).
- P_CHECK_COUNTER, 0, 1 = enable the counter-pattern checker; 0 = pattern_err_cnt held at 0.

Ports:
- clk  in  1  system sample clock; all inputs synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable, synchronous.
- adc_data  in  14  sample, one per clk.
- adc_or  in  1  over-range flag for the same sample.
- m_data  out  32  packed entropy word.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept.
- overflow  out  1  sticky: a word was dropped because the output was full.
- or_cnt  out  16  saturating count of over-range samples.
- pattern_err_cnt  out  16  saturating count of counter-pattern mismatches.
- clear_status  in  1  synchronous pulse; clears overflow, or_cnt, pattern_err_cnt.

Behaviour:
- Reset (async): every register and output = 0, including m_data, m_valid, the counts, the shift register, the bit count and checker state (SYNC).
- Input stage: adc_data, adc_or and enable are registered once (s_data, s_or, s_en). All logic below acts on the registered copies.
- A sample is valid when s_en=1 and s_or=0. If s_en=1 and s_or=1, or_cnt increments (saturates at 0xFFFF) and the sample is not packed.
- Packer:
  - Each valid sample shifts s_data[P_LSB_BITS-1:0] into the shift register at the LSB side. The first-captured bits end up in the MSBs of m_data.
  - A bit count (0..31) advances by P_LSB_BITS and wraps to 0 on word completion.
  - Completion edge (count + P_LSB_BITS = 32):
    - If the output is empty, or m_ready=1 in that cycle: m_data <= {shreg, new bits} and m_valid <= 1 on the same edge.
    - Otherwise the completed word is discarded, overflow <= 1 (sticky), and packing continues with count = 0.
- Output handshake:
  - Transfer occurs when m_valid & m_ready.
  - m_valid drops after a transfer unless a new word loads on the same edge.
  - m_data stays stable while m_valid=1 and m_ready=0.
- Latency: first sample registered at edge t0 → with P_LSB_BITS=1, m_valid=1 after edge t0+32, i.e. 33 clk from adc_data presentation.
- s_en falling (1→0):
  - Bit count and shift register clear; the partial word is discarded.
  - The checker returns to SYNC.
  - A pending output word is kept until consumed.
- Checker FSM (P_CHECK_COUNTER=1), states SYNC and RUN:
  - SYNC: on a sample with s_en=1, expected <= s_data+1 (mod 2^14), go to RUN. No check.
  - RUN: on each s_en=1 sample, compare s_data to expected.
    - Mismatch → pattern_err_cnt+1 (saturating), expected <= s_data+1 (resync).
    - Match → expected+1.
  - Wrap 0x3FFF→0x0000 is a match.
  - adc_or does not affect the checker.
- clear_status and a same-cycle increment: clear wins, so the count = 0.
- Counts saturate at 0xFFFF and never wrap.

Test Plan:
- Reset mid-stream: assert reset after 20 samples → all outputs 0 immediately (async); after release, the first word needs a full 32 new samples.
- P_LSB_BITS=1, adc_data LSBs 1,0,1,0,… from edge 1, m_ready=1 → m_valid high after edge 33 for 1 cycle, m_data=0xAAAAAAAA; next word 32 cycles later.
- m_ready=0 across two word completions → first word held unchanged, second dropped, overflow=1; clear_status → overflow=0.
- Over-range: 32 samples with adc_or=1 on every 4th → or_cnt=8, only 24 bits packed, no word yet; 8 more valid samples → word out.
- P_CHECK_COUNTER=1, counter pattern 0x3FF0..0x3FFF,0x0000..0x000F → pattern_err_cnt=0; inject 0x1234 in place of 0x0005 → cnt=1 (one mismatch, then resync), a second jump back to 0x0007 → cnt=2.
- P_LSB_BITS=4, samples with low nibbles 0x1..0x8 → m_data=0x12345678; enable dropped after 3 samples then restored → partial discarded, the next word is built only from new samples.
